// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window filter.
// Contents:
//   sobel_mode_e - runtime filter mode (pass-through, |Gx|, |Gy|, |Gx|+|Gy|)
//   PIPE_LAT     - fixed input-to-output latency in clock cycles
//   grad_w()     - width of a signed gradient for a given pixel width
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GX   = 2'd1,
    MODE_GY   = 2'd2,
    MODE_MAG  = 2'd3
  } sobel_mode_e;

  localparam int unsigned PIPE_LAT = 3;

  // A gradient is a difference of two sums of weight 4, so the magnitude needs two extra bits
  // and the sign a third.
  function automatic int unsigned grad_w(input int unsigned data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/line_buffer_2row.sv
// Two-line pixel history for the 3x3 window.
// Two IMG_W x DATA_W RAMs share one address. On each enabled beat the first RAM returns the
// pixel one line up and stores the new pixel; the second RAM returns the pixel two lines up and
// stores what the first RAM held (cascade). Reads are synchronous and see the old contents.
// Ports:
//   clk_i   - pixel clock
//   rst_i   - asynchronous active-high reset (clears the read registers only)
//   en_i    - beat enable; RAMs and read registers hold when low
//   addr_i  - column address
//   data_i  - live pixel
//   row1_o  - registered pixel from the line above (same column)
//   row2_o  - registered pixel from two lines above (same column)
module line_buffer_2row #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IMG_W  = 1280,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] row1_o,
  output logic [DATA_W-1:0] row2_o
);

  logic [DATA_W-1:0] mem0_q [IMG_W];
  logic [DATA_W-1:0] mem1_q [IMG_W];
  logic [DATA_W-1:0] row1_q, row2_q;

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem0_q[addr_i] <= data_i;
      mem1_q[addr_i] <= mem0_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row1_q <= '0;
      row2_q <= '0;
    end else if (en_i) begin
      row1_q <= mem0_q[addr_i];
      row2_q <= mem1_q[addr_i];
    end
  end

  assign row1_o = row1_q;
  assign row2_o = row2_q;

endmodule

// File: rtl/sobel_window_filter.sv
// 3x3 Sobel edge filter for a single-channel pixel stream, fixed 3-cycle latency.
//   Stage 1: counters, line-buffer read and window shift registers
//   Stage 2: signed Gx / Gy
//   Stage 3: abs, mode select, saturation (optional threshold), border masking
// Beats whose window is incomplete (row < 2 or col < 2) produce oDATA = 0 in every mode.
// Optional feature: define SOBEL_THRESH_EN to add iTHRESH; gradient modes then output
// all-ones when the saturated result is >= iTHRESH and zero otherwise.
// Ports:
//   iCLK, iRST     - pixel clock, asynchronous active-high reset
//   iSOF, iDVAL    - start of frame (qualified by iDVAL), pixel valid
//   iDATA          - input pixel
//   iMODE          - filter mode, latched on an iSOF & iDVAL beat
//   iTHRESH        - threshold (SOBEL_THRESH_EN only), sampled every cycle
//   oDVAL, oSOF    - output valid and start of frame, aligned to oDATA
//   oDATA          - filtered pixel, holds while oDVAL is low
module sobel_window_filter
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IMG_W  = 1280,
  parameter int unsigned CNT_W  = 11
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSOF,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  input  logic [1:0]        iMODE,
`ifdef SOBEL_THRESH_EN
  input  logic [DATA_W-1:0] iTHRESH,
`endif
  output logic              oDVAL,
  output logic              oSOF,
  output logic [DATA_W-1:0] oDATA
);

  localparam int unsigned GW = grad_w(DATA_W);
  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [DATA_W-1:0] MAXV = '1;

  // ---------------------------------------------------------------------------------------------
  // Position counters and mode register
  // ---------------------------------------------------------------------------------------------
  logic              sof_beat;
  logic [CNT_W-1:0]  col_q, row_q, col_d, row_d, col_cur, row_cur;
  sobel_mode_e       mode_q, mode_cur;

  assign sof_beat = iSOF & iDVAL;

  always_comb begin
    // A start-of-frame beat is pixel (0,0) regardless of where the counters were.
    col_cur  = sof_beat ? '0 : col_q;
    row_cur  = sof_beat ? '0 : row_q;
    mode_cur = sof_beat ? sobel_mode_e'(iMODE) : mode_q;
    col_d    = col_q;
    row_d    = row_q;
    if (iDVAL) begin
      if (col_cur == CNT_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_cur == '1) ? row_cur : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= MODE_PASS;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_cur;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 1: line buffers and window
  // ---------------------------------------------------------------------------------------------
  logic [DATA_W-1:0]          lb_row1, lb_row2;
  logic [DATA_W-1:0]          pix_q;
  logic [2:0][DATA_W-1:0]     win_c0_q, win_c1_q, win_c2;
  logic                       s1_valid_q, s1_sof_q, s1_border_q;
  sobel_mode_e                s1_mode_q;

  line_buffer_2row #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .ADDR_W (AW)
  ) u_line_buffer (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .en_i   (iDVAL),
    .addr_i (col_cur[AW-1:0]),
    .data_i (iDATA),
    .row1_o (lb_row1),
    .row2_o (lb_row2)
  );

  // Right-hand window column, index 0 = top (two lines up), 2 = live row.
  assign win_c2 = {pix_q, lb_row1, lb_row2};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pix_q       <= '0;
      win_c0_q    <= '0;
      win_c1_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_border_q <= 1'b0;
      s1_mode_q   <= MODE_PASS;
    end else begin
      s1_valid_q <= iDVAL;
      s1_sof_q   <= sof_beat;
      if (iDVAL) begin
        pix_q       <= iDATA;
        // The right column of the previous beat becomes the middle column of this one.
        win_c1_q    <= win_c2;
        win_c0_q    <= win_c1_q;
        s1_border_q <= (row_cur < CNT_W'(2)) || (col_cur < CNT_W'(2));
        s1_mode_q   <= mode_cur;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2: gradients
  // ---------------------------------------------------------------------------------------------
  logic [DATA_W-1:0]   p [3][3];
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic                s2_valid_q, s2_sof_q, s2_border_q;
  sobel_mode_e         s2_mode_q;
  logic [DATA_W-1:0]   s2_center_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      p[i][0] = win_c0_q[i];
      p[i][1] = win_c1_q[i];
      p[i][2] = win_c2[i];
    end
    gx_d = $signed((GW'(p[0][2]) + (GW'(p[1][2]) << 1) + GW'(p[2][2]))
                 - (GW'(p[0][0]) + (GW'(p[1][0]) << 1) + GW'(p[2][0])));
    gy_d = $signed((GW'(p[2][0]) + (GW'(p[2][1]) << 1) + GW'(p[2][2]))
                 - (GW'(p[0][0]) + (GW'(p[0][1]) << 1) + GW'(p[0][2])));
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      gx_q        <= '0;
      gy_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_border_q <= 1'b0;
      s2_mode_q   <= MODE_PASS;
      s2_center_q <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_sof_q   <= s1_sof_q;
      if (s1_valid_q) begin
        gx_q        <= gx_d;
        gy_q        <= gy_d;
        s2_border_q <= s1_border_q;
        s2_mode_q   <= s1_mode_q;
        s2_center_q <= p[1][1];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 3: magnitude, select, saturate, mask
  // ---------------------------------------------------------------------------------------------
  logic [GW-1:0]     ax, ay, mag;
  logic [DATA_W-1:0] sat, res;
  logic              out_dval_q, out_sof_q;
  logic [DATA_W-1:0] out_data_q;

  always_comb begin
    ax  = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay  = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag = '0;
    unique case (s2_mode_q)
      MODE_PASS: mag = '0;
      MODE_GX:   mag = ax;
      MODE_GY:   mag = ay;
      MODE_MAG:  mag = ax + ay;
      default:   mag = '0;
    endcase
    sat = (mag > GW'(MAXV)) ? MAXV : mag[DATA_W-1:0];
    if (s2_border_q) begin
      res = '0;
    end else if (s2_mode_q == MODE_PASS) begin
      res = s2_center_q;
    end else begin
`ifdef SOBEL_THRESH_EN
      res = (sat >= iTHRESH) ? MAXV : '0;
`else
      res = sat;
`endif
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      out_dval_q <= 1'b0;
      out_sof_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_dval_q <= s2_valid_q;
      out_sof_q  <= s2_sof_q;
      if (s2_valid_q) begin
        out_data_q <= res;
      end
    end
  end

  assign oDVAL = out_dval_q;
  assign oSOF  = out_sof_q;
  assign oDATA = out_data_q;

endmodule
